sort_array: RTL
===============

# sort_array

Parametrised systolic insertion sorter: a chain of `DEPTH` compare-and-insert cells that accepts one `DATA_W`-bit item per cycle and, once a frame is complete, streams the items out in sorted order at one per cycle. It generalises the single sort-register cell into a configurable-width, configurable-depth array with valid/ready handshakes, frame delimiting and a per-frame ascending/descending mode. It sits between a streaming producer and any consumer that needs sorted frames.

## Interface
- `DATA_W`, 8, item width in bits (≥1)
- `DEPTH`, 8, number of cells = maximum frame length (≥2)
- `clk`  input  1  clock; all state updates on the rising edge
- `rst`  input  1  reset, asynchronous and active-high
- `in_valid`  input  1  producer has an item
- `in_ready`  output  1  array accepts items (LOAD state)
- `in_data`  input  DATA_W  item, unsigned
- `in_last`  input  1  qualifies the final item of a frame
- `descend`  input  1  0 = ascending, 1 = descending; sampled with the first item of a frame
- `out_valid`  output  1  sorted item available
- `out_ready`  input  1  consumer takes the item
- `out_data`  output  DATA_W  current sorted item (contents of cell 0)
- `out_last`  output  1  `out_data` is the final item of the frame

## Operation
- States: LOAD, DRAIN. Reset → LOAD, all cells invalid with value 0, `count` = 0, mode register = 0.
- Each cell i holds `val[i]`, `vld[i]`. Ordering: cell 0 holds the first item to output.
- Accept = `in_valid && in_ready`. On accept, per cell: `ins[i] = !vld[i] || (mode ? in_data > val[i] : in_data < val[i])` (strict compare; equal items go behind existing equals). Cell i loads `in_data` if `ins[i] && !ins[i-1]`, loads `val[i-1]`/`vld[i-1]` if `ins[i-1]`, else holds. `ins[-1]` = 0.
- Accept with `count` = 0 latches `descend` into the mode register for the frame.
- `count` increments on accept, width `$clog2(DEPTH+1)`.
- LOAD → DRAIN on accept with `in_last` = 1, or on accept that makes `count` = `DEPTH` (implicit frame end, `in_last` ignored).
- In DRAIN: `in_ready` = 0; `out_valid` = 1 while `count` > 0. On `out_valid && out_ready`, every cell i loads cell i+1; last cell becomes invalid, value 0; `count` decrements.
- `out_last` = `out_valid && count == 1`. Pop with `count` = 1 → LOAD.
- `in_ready` = (state == LOAD); no overlap of load and drain.
- `in_data` is don't-care when not accepted; outputs never depend combinationally on `in_*` or `out_ready`.

## Timing
- Reset values: `in_ready` 1, `out_valid` 0, `out_data` 0, `out_last` 0; asserting `rst` mid-frame or mid-drain forces these immediately and discards all data.
- Throughput 1 item/cycle in both directions.
- Latency: frame-closing item accepted at edge t → `out_valid` high after edge t, `out_data` = min (max if descending) including that item.
- Frame of N items: drain takes exactly N cycles with `out_ready` held high; `in_ready` rises the cycle after the pop of the `out_last` item.
- `out_valid && !out_ready`: `out_data`, `out_last` held stable.

## Structure
- Package `sort_pkg`: state enum (`LOAD`, `DRAIN`), helper function `cmp_ins(a, b, desc)` implementing the strict compare.
- Sub-module `sort_cell` (one per cell, `DATA_W` parameter): holds `val`/`vld`, computes `ins` from its neighbour's `ins`, performs insert/shift-right/shift-left. `sort_array` owns FSM, `count`, mode register and generate loop.

## Test plan
DATA_W=8, DEPTH=4:
- Ascending: AA, 0B, 05, 04 (last on 04) → out 04, 05, 0B, AA; `out_last` only with AA.
- Descending (`descend`=1 on first item): AA, 0B, 05, 04 → out AA, 0B, 05, 04; mode change mid-frame ignored.
- Short frame 11, 0A (last on 0A) → out 0A, 11; `in_ready` 1 the cycle after pop of 11; next frame 03 (last) → out 03.
- Full without `in_last`: 05, 03, 05, 03 → DRAIN after 4th; 5th `in_valid` stalls (`in_ready` 0); out 03, 03, 05, 05.
- Backpressure: toggle `out_ready` every cycle during drain → each item held until taken, no loss or duplicate.
- Reset after two pops → `out_valid` 0, `in_ready` 1 immediately; next frame 07, 01 (last) → out 01, 07, no stale data.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and the insertion compare used by every cell of the sorter.
package sort_pkg;

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Widest item the shared compare accepts; callers zero-extend, so unsigned order is preserved.
    localparam int MAX_W = 64;

    // Strict compare: equal items never displace an existing equal, which keeps arrival order among ties.
    function automatic logic cmp_ins(input logic [MAX_W-1:0] a,
                                     input logic [MAX_W-1:0] b,
                                     input logic             desc);
        return desc ? (a > b) : (a < b);
    endfunction

endpackage

// File: rtl/sort_cell.sv
// One compare-and-insert stage: inserts, shifts right on insert and shifts left on drain.
module sort_cell
    import sort_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic              pop,
    input  logic              mode,
    input  logic [DATA_W-1:0] in_data,
    input  logic              prev_ins,
    input  logic [DATA_W-1:0] prev_val,
    input  logic              prev_vld,
    input  logic [DATA_W-1:0] next_val,
    input  logic              next_vld,
    output logic              ins,
    output logic [DATA_W-1:0] val,
    output logic              vld
);

    logic [DATA_W-1:0] val_reg;
    logic              vld_reg;

    assign ins = !vld_reg || cmp_ins(MAX_W'(in_data), MAX_W'(val_reg), mode);
    assign val = val_reg;
    assign vld = vld_reg;

    // Load and drain never overlap, so accept and pop are mutually exclusive here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_reg <= '0;
            vld_reg <= 1'b0;
        end else if (accept) begin
            if (prev_ins) begin
                val_reg <= prev_val;
                vld_reg <= prev_vld;
            end else if (ins) begin
                val_reg <= in_data;
                vld_reg <= 1'b1;
            end
        end else if (pop) begin
            val_reg <= next_val;
            vld_reg <= next_vld;
        end
    end

endmodule

// File: rtl/sort_array.sv
// Systolic insertion sorter: loads a frame one item per cycle, then streams it out sorted.
module sort_array
    import sort_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              descend,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DEPTH - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);

    state_t            state_reg, state_next;
    logic [CW-1:0]     count_reg;
    logic              mode_reg;
    logic              accept, pop;

    logic [DEPTH-1:0][DATA_W-1:0] vals;
    logic [DEPTH-1:0]             vlds;
    logic [DEPTH-1:0]             ins;

    assign in_ready  = (state_reg == LOAD);
    assign out_valid = (state_reg == DRAIN) && (count_reg != '0);
    assign out_data  = vals[0];
    assign out_last  = out_valid && (count_reg == ONE);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LOAD: begin
                // A full array closes the frame even without in_last.
                if (accept && (in_last || count_reg == FULL_M1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && count_reg == ONE) begin
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            mode_reg  <= 1'b0;
        end else begin
            if (accept) begin
                count_reg <= count_reg + ONE;
                if (count_reg == '0) begin
                    mode_reg <= descend;
                end
            end else if (pop) begin
                count_reg <= count_reg - ONE;
            end
        end
    end

    // The mode register is stale for the first item, but every cell is empty then, so ins is 1 everywhere.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
            logic              prev_ins;
            logic [DATA_W-1:0] prev_val;
            logic              prev_vld;
            logic [DATA_W-1:0] next_val;
            logic              next_vld;

            if (gi == 0) begin : g_head
                assign prev_ins = 1'b0;
                assign prev_val = '0;
                assign prev_vld = 1'b0;
            end else begin : g_body
                assign prev_ins = ins[gi-1];
                assign prev_val = vals[gi-1];
                assign prev_vld = vlds[gi-1];
            end

            if (gi == DEPTH - 1) begin : g_tail
                assign next_val = '0;
                assign next_vld = 1'b0;
            end else begin : g_inner
                assign next_val = vals[gi+1];
                assign next_vld = vlds[gi+1];
            end

            sort_cell #(
                .DATA_W(DATA_W)
            ) u_cell (
                .clk     (clk),
                .rst     (rst),
                .accept  (accept),
                .pop     (pop),
                .mode    (mode_reg),
                .in_data (in_data),
                .prev_ins(prev_ins),
                .prev_val(prev_val),
                .prev_vld(prev_vld),
                .next_val(next_val),
                .next_vld(next_vld),
                .ins     (ins[gi]),
                .val     (vals[gi]),
                .vld     (vlds[gi])
            );
        end
    endgenerate

    // The last cell feeds no neighbour on the insert side.
    logic unused_tail;
    assign unused_tail = ^{ins[DEPTH-1], vlds[DEPTH-1], vals[DEPTH-1]};

endmodule
